// File: rtl/reg_mem_dp.sv
// ---------------------------------------------------------------------------
// reg_mem_dp
// Register-based memory with one write port, one registered read port and a
// sequential whole-array clear. After reset, and after every clr request, the
// array is walked one word per clock and written with zero; while that walk is
// running the block reports busy and ignores read/write requests.
//
// Ports
//   clk    in   1           single clock, rising edge
//   rst    in   1           synchronous active-high reset (starts a clear)
//   wen    in   1           write request
//   waddr  in   ADDR_BITS   write address
//   wdata  in   DATA_WIDTH  write data
//   ren    in   1           read request
//   raddr  in   ADDR_BITS   read address
//   rdata  out  DATA_WIDTH  registered read data, held between reads
//   rvalid out  1           one-cycle strobe marking a fresh rdata
//   clr    in   1           one-cycle request to zero the whole array
//   busy   out  1           array is being cleared, requests dropped
// ---------------------------------------------------------------------------
module reg_mem_dp #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 4,
    parameter int READ_BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  clr,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_BITS-1:0]  r_ptr;
    logic [ADDR_BITS-1:0]  w_ptr_nxt;
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  w_idle_free;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_bypass_hit;

    // Requests are accepted only in IDLE and only when no clear is being requested.
    always_comb begin
        w_idle_free  = (r_state == ST_IDLE) && !clr;
        w_wr_acc     = w_idle_free && wen;
        w_rd_acc     = w_idle_free && ren;
        w_bypass_hit = (READ_BYPASS != 0) && w_wr_acc && (waddr == raddr);
    end

    // Next-state and clear-pointer logic for the IDLE/CLEAR controller.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = {ADDR_BITS{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // ptr wraps to 0 naturally on the last word
                w_ptr_nxt = r_ptr + ADDR_BITS'(1);
                if (r_ptr == {ADDR_BITS{1'b1}}) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = {ADDR_BITS{1'b0}};
            end
        endcase
    end

    // Controller state register; reset parks the FSM in CLEAR at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_ptr   <= {ADDR_BITS{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Array write port: the clear walk owns the port while in CLEAR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_ptr] <= {DATA_WIDTH{1'b0}};
            end else if (w_wr_acc) begin
                r_mem[waddr] <= wdata;
            end
        end
    end

    // Registered read port; rdata holds its value whenever no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= {DATA_WIDTH{1'b0}};
            r_rvalid <= 1'b0;
        end else if (w_rd_acc) begin
            r_rdata  <= w_bypass_hit ? wdata : r_mem[raddr];
            r_rvalid <= 1'b1;
        end else begin
            r_rvalid <= 1'b0;
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign busy   = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_reg_mem_dp.sv
// ---------------------------------------------------------------------------
// tb_reg_mem_dp
// Directed bench for reg_mem_dp (DATA_WIDTH=8, ADDR_BITS=4). Stimulus pushes
// the hand-computed read result into a queue whenever it issues a read that
// should be accepted; a monitor on the falling edge pops and compares each
// time the DUT raises rvalid, and flags any rvalid with nothing expected.
// ---------------------------------------------------------------------------
module tb_reg_mem_dp;

    localparam int DW = 8;
    localparam int AB = 4;
    localparam int RB = 1;

    logic          clk;
    logic          rst;
    logic          wen;
    logic [AB-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          ren;
    logic [AB-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          clr;
    logic          busy;

    logic [DW-1:0] exp_q [$];
    int            n_pass;
    int            n_total;

    reg_mem_dp #(
        .DATA_WIDTH  (DW),
        .ADDR_BITS   (AB),
        .READ_BYPASS (RB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wen    (wen),
        .waddr  (waddr),
        .wdata  (wdata),
        .ren    (ren),
        .raddr  (raddr),
        .rdata  (rdata),
        .rvalid (rvalid),
        .clr    (clr),
        .busy   (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        if (rvalid) begin
            n_total = n_total + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL rvalid_unexpected: rvalid=1 rdata=%02h, required no read pending", rdata);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rdata === e) n_pass = n_pass + 1;
                else $display("FAIL read_data: got %02h, required %02h", rdata, e);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total = n_total + 1;
        if (act === req) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AB-1:0] a, input logic [DW-1:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic do_read(input logic [AB-1:0] a, input logic [DW-1:0] e);
        ren = 1'b1; raddr = a;
        exp_q.push_back(e);
        tick();
        ren = 1'b0;
    endtask

    // Counts falling edges with busy high, starting now; bounded by a budget.
    task automatic count_busy(input string name, input int req);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            cnt = cnt + 1;
            if (rvalid !== 1'b0) begin
                n_total = n_total + 1;
                $display("FAIL %s_rvalid_while_busy: got %b, required 0", name, rvalid);
            end
        end
        check(name, 32'(cnt), 32'(req));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1; wen = 1'b0; ren = 1'b0; clr = 1'b0;
        waddr = '0; raddr = '0; wdata = '0;

        // Reset held two cycles
        tick();
        tick();
        check("reset_busy",   32'(busy),   32'd1);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata",  32'(rdata),  32'h00);
        rst = 1'b0;
        count_busy("reset_busy_cycles", 16);

        // Whole array reads zero, back-to-back reads
        for (int i = 0; i < 16; i++) do_read(AB'(i), 8'h00);
        tick();

        // Write then read with 1-cycle latency, rdata held afterwards
        do_write(4'd3, 8'hA5);
        do_read(4'd3, 8'hA5);
        tick();
        check("rvalid_drop", 32'(rvalid), 32'd0);
        check("rdata_hold",  32'(rdata),  32'hA5);

        // Same-address read-during-write
        do_write(4'd7, 8'h11);
        wen = 1'b1; waddr = 4'd7; wdata = 8'h3C;
        do_read(4'd7, (RB != 0) ? 8'h3C : 8'h11);
        wen = 1'b0;
        do_read(4'd7, 8'h3C);

        // Different-address read and write in the same cycle are independent
        wen = 1'b1; waddr = 4'd9; wdata = 8'h5A;
        do_read(4'd3, 8'hA5);
        wen = 1'b0;
        do_read(4'd9, 8'h5A);
        tick();
        check("write_keeps_rdata", 32'(rdata), 32'h5A);

        // clr wins over a simultaneous write and read
        do_write(4'd0,  8'hFF);
        do_write(4'd15, 8'hFF);
        clr = 1'b1; wen = 1'b1; waddr = 4'd5; wdata = 8'h77; ren = 1'b1; raddr = 4'd3;
        tick();
        clr = 1'b0;
        check("clr_rvalid_dropped", 32'(rvalid), 32'd0);
        check("clr_busy",           32'(busy),   32'd1);
        // Requests kept asserted throughout the clear must have no effect
        waddr = 4'd8; wdata = 8'hEE; raddr = 4'd8;
        count_busy("clr_busy_cycles", 16);
        wen = 1'b0; ren = 1'b0;
        do_read(4'd0,  8'h00);
        do_read(4'd5,  8'h00);
        do_read(4'd15, 8'h00);
        do_read(4'd8,  8'h00);
        do_read(4'd3,  8'h00);
        tick();

        // Reset on the 5th cycle of a clear restarts the walk
        do_write(4'd2, 8'h42);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_clear_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_clear_busy_in_rst1", 32'(busy), 32'd1);
        tick();
        check("mid_clear_busy_in_rst2", 32'(busy), 32'd1);
        rst = 1'b0;
        count_busy("restart_busy_cycles", 16);
        do_read(4'd2,  8'h00);
        do_read(4'd15, 8'h00);
        tick();
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
